// File: rtl/mano_seq_ctrl_if.sv
// Signal bundle between the Mano sequence controller and its datapath/memory.
// The master side is the controller; the slave side is the datapath/memory.
interface mano_seq_ctrl_if;
  logic        start;
  logic        halt_req;
  logic [7:0]  ir_q;
  logic        mem_ack;
  logic        exec_done;
  logic [3:0]  sc;
  logic [15:0] t_state;
  logic [7:0]  d_bus;
  logic        i_flag;
  logic        ld_ar_pc;
  logic        mem_rd;
  logic        ld_ir;
  logic        inc_pc;
  logic        ld_ar_ir;
  logic        ld_ar_mem;
  logic        exec_en;
  logic        halted;
  logic        timeout;

  modport master (
    input  start, halt_req, ir_q, mem_ack, exec_done,
    output sc, t_state, d_bus, i_flag, ld_ar_pc, mem_rd, ld_ir, inc_pc,
           ld_ar_ir, ld_ar_mem, exec_en, halted, timeout
  );

  modport slave (
    output start, halt_req, ir_q, mem_ack, exec_done,
    input  sc, t_state, d_bus, i_flag, ld_ar_pc, mem_rd, ld_ir, inc_pc,
           ld_ar_ir, ld_ar_mem, exec_en, halted, timeout
  );
endinterface

// File: rtl/mano_seq_ctrl.sv
// Sequence counter and timing controller for the 8-bit Mano basic computer.
//
// state  | meaning
// IDLE   | after reset, sc=0, waits for start
// FETCH0 | T0, AR<-PC
// FETCH1 | T1, read M[AR], IR<-M[AR] and PC<-PC+1 on ack
// DECODE | T2, AR<-IR[3:0], latch opcode decode and I bit
// ADDR   | T3, first execute cycle (D7), indirect read, or empty (direct)
// EXEC   | T4+, execute until exec_done or sc reaches MAX_SC
// HALT   | stopped, sc=0, waits for start
module mano_seq_ctrl #(
  parameter int MAX_SC = 15
) (
  input logic           clk,
  input logic           rst_n,
  mano_seq_ctrl_if.master bus
);

  localparam logic [3:0] SC_LAST = 4'(MAX_SC);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH0 = 3'd1,
    FETCH1 = 3'd2,
    DECODE = 3'd3,
    ADDR   = 3'd4,
    EXEC   = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t     state, state_nx;
  logic [3:0] sc_q, sc_nx;
  logic       timeout_q, timeout_nx;
  logic [7:0] d_q;
  logic       i_q;

  logic ld_ar_pc, mem_rd, ld_ir, inc_pc, ld_ar_ir, ld_ar_mem, exec_en;

  // The address field of IR goes straight to the datapath, not through here.
  logic unused_addr;
  assign unused_addr = ^bus.ir_q[3:0];

  // State, sequence counter and sticky timeout registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sc_q      <= 4'd0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nx;
      sc_q      <= sc_nx;
      timeout_q <= timeout_nx;
    end
  end

  // Opcode decode and indirect bit, captured at T2 and held until the next T2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 8'd0;
      i_q <= 1'b0;
    end else if (state == DECODE) begin
      d_q <= 8'd1 << bus.ir_q[6:4];
      i_q <= bus.ir_q[7];
    end
  end

  // Next state, next sequence count and the one-cycle strobes.
  always_comb begin
    state_nx   = state;
    timeout_nx = timeout_q;
    ld_ar_pc   = 1'b0;
    mem_rd     = 1'b0;
    ld_ir      = 1'b0;
    inc_pc     = 1'b0;
    ld_ar_ir   = 1'b0;
    ld_ar_mem  = 1'b0;
    exec_en    = 1'b0;

    case (state)
      IDLE, HALT: begin
        if (bus.start) begin
          state_nx   = FETCH0;
          timeout_nx = 1'b0;
        end
      end
      FETCH0: begin
        ld_ar_pc = 1'b1;
        state_nx = FETCH1;
      end
      FETCH1: begin
        mem_rd = 1'b1;
        if (bus.mem_ack) begin
          ld_ir    = 1'b1;
          inc_pc   = 1'b1;
          state_nx = DECODE;
        end
      end
      DECODE: begin
        ld_ar_ir = 1'b1;
        state_nx = ADDR;
      end
      ADDR: begin
        if (d_q[7]) begin
          // Register/IO instructions have no operand fetch, so T3 already executes.
          exec_en = 1'b1;
        end else if (i_q) begin
          mem_rd = 1'b1;
          if (bus.mem_ack) begin
            ld_ar_mem = 1'b1;
            state_nx  = EXEC;
          end
        end else begin
          state_nx = EXEC;
        end
      end
      EXEC: begin
        exec_en = 1'b1;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    // Shared exit rules for any cycle with the execute phase active.
    if (exec_en) begin
      if (bus.exec_done) begin
        state_nx = bus.halt_req ? HALT : FETCH0;
      end else if (sc_q == SC_LAST) begin
        timeout_nx = 1'b1;
        state_nx   = HALT;
      end else begin
        state_nx = EXEC;
      end
    end

    // sc restarts at fetch, holds during memory waits, otherwise steps by one.
    case (state_nx)
      IDLE, FETCH0, HALT: sc_nx = 4'd0;
      default: begin
        if (state_nx == state && state != EXEC) sc_nx = sc_q;
        else                                    sc_nx = sc_q + 4'd1;
      end
    endcase
  end

  // Output mapping.
  always_comb begin
    bus.sc        = sc_q;
    bus.t_state   = (state == IDLE || state == HALT) ? 16'd0 : (16'd1 << sc_q);
    bus.d_bus     = d_q;
    bus.i_flag    = i_q;
    bus.ld_ar_pc  = ld_ar_pc;
    bus.mem_rd    = mem_rd;
    bus.ld_ir     = ld_ir;
    bus.inc_pc    = inc_pc;
    bus.ld_ar_ir  = ld_ar_ir;
    bus.ld_ar_mem = ld_ar_mem;
    bus.exec_en   = exec_en;
    bus.halted    = (state == HALT);
    bus.timeout   = timeout_q;
  end

endmodule

// File: tb/tb_mano_seq_ctrl.sv
// Directed bench for mano_seq_ctrl: each step queues the expected output
// vector and compares it against the DUT at the following falling edge.
module tb_mano_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  mano_seq_ctrl_if bus ();

  mano_seq_ctrl #(.MAX_SC(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // strobe/flag field order: ld_ar_pc mem_rd ld_ir inc_pc ld_ar_ir ld_ar_mem exec_en halted timeout
  localparam logic [8:0] NONE = 9'h000;
  localparam logic [8:0] ARPC = 9'h100;
  localparam logic [8:0] RD   = 9'h080;
  localparam logic [8:0] LDIR = 9'h040;
  localparam logic [8:0] INC  = 9'h020;
  localparam logic [8:0] ARIR = 9'h010;
  localparam logic [8:0] ARM  = 9'h008;
  localparam logic [8:0] EX   = 9'h004;
  localparam logic [8:0] HLT  = 9'h002;
  localparam logic [8:0] TO   = 9'h001;

  int n_vec  = 0;
  int n_miss = 0;

  logic [37:0] exp_q[$];
  string       tag_q[$];
  logic [37:0] obs;

  assign obs = {bus.sc, bus.t_state, bus.d_bus, bus.i_flag,
                bus.ld_ar_pc, bus.mem_rd, bus.ld_ir, bus.inc_pc, bus.ld_ar_ir,
                bus.ld_ar_mem, bus.exec_en, bus.halted, bus.timeout};

  function automatic logic [37:0] ev(input int s, input bit act,
                                     input logic [7:0] d, input bit i,
                                     input logic [8:0] st);
    logic [15:0] t;
    t = act ? (16'd1 << s) : 16'd0;
    return {4'(s), t, d, i, st};
  endfunction

  task automatic compare_head();
    logic [37:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_vec++;
    assert (obs === e)
    else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  // Queue the expectation now, compare at the falling edge, then move past the next rising edge.
  task automatic step(input string tag, input logic [37:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    compare_head();
    @(posedge clk);
    #1;
  endtask

  // Compare without waiting for a clock edge (asynchronous reset effects).
  task automatic check_now(input string tag, input logic [37:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    compare_head();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.halt_req  = 1'b0;
    bus.ir_q      = 8'h00;
    bus.mem_ack   = 1'b0;
    bus.exec_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step("reset", ev(0, 0, 8'h00, 0, NONE));
    rst_n = 1'b1;

    // stray handshakes in IDLE do nothing
    bus.mem_ack = 1'b1; bus.exec_done = 1'b1;
    step("idle_stray0", ev(0, 0, 8'h00, 0, NONE));
    step("idle_stray1", ev(0, 0, 8'h00, 0, NONE));
    bus.mem_ack = 1'b0; bus.exec_done = 1'b0;

    // direct instruction 0x23, zero-wait read, exec_done at T4
    bus.ir_q = 8'h23; bus.start = 1'b1;
    step("d_idle_start", ev(0, 0, 8'h00, 0, NONE));
    bus.start = 1'b0;
    step("d_t0", ev(0, 1, 8'h00, 0, ARPC));
    bus.mem_ack = 1'b1;
    step("d_t1", ev(1, 1, 8'h00, 0, RD | LDIR | INC));
    bus.mem_ack = 1'b0;
    step("d_t2", ev(2, 1, 8'h00, 0, ARIR));
    step("d_t3", ev(3, 1, 8'h04, 0, NONE));
    bus.exec_done = 1'b1;
    step("d_t4", ev(4, 1, 8'h04, 0, EX));
    bus.exec_done = 1'b0;
    bus.ir_q = 8'h95;
    step("d_next_t0", ev(0, 1, 8'h04, 0, ARPC));

    // indirect instruction 0x95, operand read acked on the fourth cycle
    bus.mem_ack = 1'b1;
    step("i_t1", ev(1, 1, 8'h04, 0, RD | LDIR | INC));
    bus.mem_ack = 1'b0;
    step("i_t2", ev(2, 1, 8'h04, 0, ARIR));
    step("i_t3_wait1", ev(3, 1, 8'h02, 1, RD));
    step("i_t3_wait2", ev(3, 1, 8'h02, 1, RD));
    step("i_t3_wait3", ev(3, 1, 8'h02, 1, RD));
    bus.mem_ack = 1'b1;
    step("i_t3_ack", ev(3, 1, 8'h02, 1, RD | ARM));
    bus.mem_ack = 1'b0;
    step("i_t4", ev(4, 1, 8'h02, 1, EX));
    step("i_t5", ev(5, 1, 8'h02, 1, EX));
    bus.exec_done = 1'b1;
    step("i_t6", ev(6, 1, 8'h02, 1, EX));
    bus.exec_done = 1'b0;
    bus.ir_q = 8'h70;
    step("i_next_t0", ev(0, 1, 8'h02, 1, ARPC));

    // register/IO instruction 0x70 completes at T3, mem_ack there is ignored
    bus.mem_ack = 1'b1;
    step("r_t1", ev(1, 1, 8'h02, 1, RD | LDIR | INC));
    bus.mem_ack = 1'b0;
    step("r_t2", ev(2, 1, 8'h02, 1, ARIR));
    bus.exec_done = 1'b1; bus.mem_ack = 1'b1;
    step("r_t3", ev(3, 1, 8'h80, 0, EX));
    bus.exec_done = 1'b0; bus.mem_ack = 1'b0;
    bus.ir_q = 8'h23;
    step("r_next_t0", ev(0, 1, 8'h80, 0, ARPC));

    // halt_req only matters in the exec_done cycle
    bus.mem_ack = 1'b1; bus.halt_req = 1'b1;
    step("h_t1", ev(1, 1, 8'h80, 0, RD | LDIR | INC));
    bus.mem_ack = 1'b0; bus.halt_req = 1'b0;
    step("h_t2", ev(2, 1, 8'h80, 0, ARIR));
    step("h_t3", ev(3, 1, 8'h04, 0, NONE));
    bus.exec_done = 1'b1; bus.halt_req = 1'b1;
    step("h_t4", ev(4, 1, 8'h04, 0, EX));
    bus.exec_done = 1'b0; bus.halt_req = 1'b0;
    step("h_halt0", ev(0, 0, 8'h04, 0, HLT));
    bus.exec_done = 1'b1;
    step("h_halt1", ev(0, 0, 8'h04, 0, HLT));
    bus.exec_done = 1'b0; bus.start = 1'b1;
    step("h_halt_start", ev(0, 0, 8'h04, 0, HLT));
    bus.start = 1'b0;
    step("h_restart_t0", ev(0, 1, 8'h04, 0, ARPC));

    // execute phase that never finishes: timeout at sc=15, then HALT
    bus.mem_ack = 1'b1;
    step("to_t1", ev(1, 1, 8'h04, 0, RD | LDIR | INC));
    bus.mem_ack = 1'b0;
    step("to_t2", ev(2, 1, 8'h04, 0, ARIR));
    step("to_t3", ev(3, 1, 8'h04, 0, NONE));
    for (int k = 4; k <= 15; k++) begin
      step($sformatf("to_t%0d", k), ev(k, 1, 8'h04, 0, EX));
    end
    step("to_halt0", ev(0, 0, 8'h04, 0, HLT | TO));
    bus.start = 1'b1;
    step("to_halt_start", ev(0, 0, 8'h04, 0, HLT | TO));
    bus.start = 1'b0;
    step("to_cleared_t0", ev(0, 1, 8'h04, 0, ARPC));

    // reset while the fetch read is waiting
    step("rst_t1_wait0", ev(1, 1, 8'h04, 0, RD));
    step("rst_t1_wait1", ev(1, 1, 8'h04, 0, RD));
    rst_n = 1'b0;
    check_now("rst_async", ev(0, 0, 8'h00, 0, NONE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.mem_ack = 1'b1; bus.exec_done = 1'b1;
    step("rst_idle_stray0", ev(0, 0, 8'h00, 0, NONE));
    step("rst_idle_stray1", ev(0, 0, 8'h00, 0, NONE));
    bus.mem_ack = 1'b0; bus.exec_done = 1'b0; bus.start = 1'b1;
    step("rst_idle_start", ev(0, 0, 8'h00, 0, NONE));
    bus.start = 1'b0;
    step("rst_resume_t0", ev(0, 1, 8'h00, 0, ARPC));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mano_seq_ctrl.md
# mano_seq_ctrl

Sequence-counter and timing controller for the 8-bit Mano basic computer. It drives the fetch–decode–execute cycle around the instruction register, program counter and memory port. It generates the T-state sequence and one-cycle load/increment strobes, and decodes the 3-bit opcode to a one-hot D bus. It supports variable-length execute phases through an `exec_done` handshake.

## Interface
- `MAX_SC`, 15, highest sequence-counter value before timeout (4-bit counter).
- `clk` in 1: single system clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: leave IDLE or HALT and begin fetch.
- `halt_req` in 1: stop after the current instruction completes.
- `ir_q` in 8: IR contents; `[7]` = I, `[6:4]` = opcode, `[3:0]` = address.
- `mem_ack` in 1: memory read complete; data valid this cycle.
- `exec_done` in 1: datapath finished the current execute phase.
- `sc` out 4: sequence counter value.
- `t_state` out 16: one-hot decode of `sc`; all zero when IDLE or HALT.
- `d_bus` out 8: one-hot opcode decode, held from T2 until the next T2.
- `i_flag` out 1: latched `ir_q[7]`.
- `ld_ar_pc` out 1: AR←PC strobe.
- `mem_rd` out 1: memory read request.
- `ld_ir` out 1: IR←M[AR] strobe.
- `inc_pc` out 1: PC←PC+1 strobe.
- `ld_ar_ir` out 1: AR←IR[3:0] strobe.
- `ld_ar_mem` out 1: AR←M[AR][3:0] strobe, for indirect addressing.
- `exec_en` out 1: execute phase active.
- `halted` out 1: controller is in HALT.
- `timeout` out 1: sticky flag; execute phase exceeded `MAX_SC`.

## Operation
States and actions:
- **IDLE**: `sc`=0. On `start`, go to FETCH0.
- **FETCH0 (T0)**: assert `ld_ar_pc` for one cycle. Go to FETCH1.
- **FETCH1 (T1)**: hold `mem_rd` high until `mem_ack`. In the `mem_ack` cycle, pulse `ld_ir` and `inc_pc`, then go to DECODE. `sc` stays 1 during the wait.
- **DECODE (T2)**:
  - Pulse `ld_ar_ir`.
  - Register `d_bus` ← 1<<`ir_q[6:4]` and `i_flag` ← `ir_q[7]`. Both are visible from the next cycle.
  - Go to ADDR.
- **ADDR (T3)**: branches on `d_bus[7]` and `i_flag`:
  - If `d_bus[7]`=1 (register/IO instruction), this cycle is the first execute cycle. `exec_en`=1 and EXEC rules apply.
  - Else if `i_flag`=1, hold `mem_rd` until `mem_ack`. Pulse `ld_ar_mem` in the ack cycle, then go to EXEC.
  - Else (direct), the cycle is empty. Go to EXEC.
- **EXEC (T4 onward)**:
  - `exec_en`=1 and `sc` increments every cycle.
  - On `exec_done`, go to FETCH0 with `sc`←0. If `halt_req` is high in that cycle, go to HALT instead.
  - If `sc`=`MAX_SC` and `exec_done`=0, set `timeout` and go to HALT.
- **HALT**: `halted`=1 and `sc`=0. On `start`, go to FETCH0. `start` also clears `timeout`.

Rules:
- `mem_ack` is ignored unless `mem_rd`=1.
- `exec_done` is ignored unless `exec_en`=1.
- `start` is ignored outside IDLE and HALT.
- `halt_req` is sampled only in the `exec_done` cycle.
- `sc` never wraps. The timeout exit occurs at `MAX_SC`.
- `t_state[sc]`=1 in all states except IDLE and HALT.
- All strobe outputs are combinational from the current state plus `mem_ack`/`exec_done`, and are glitch-free relative to `clk`. `d_bus`, `i_flag`, `sc` and `timeout` are registered.

## Timing
- Reset (async, immediate) sets:
  - state=IDLE, `sc`=0, `t_state`=0, `d_bus`=0, `i_flag`=0;
  - all strobes=0, `mem_rd`=0, `exec_en`=0, `halted`=0, `timeout`=0.
- Reset mid-instruction aborts with no further strobes. Operation resumes only after `rst_n` rises and `start` is asserted.
- The `start` edge is followed by FETCH0 on the next cycle.
- Minimum instruction length with zero-wait memory and `exec_done` in the first execute cycle:
  - register/IO (D7): 4 cycles (T0–T3);
  - direct: 5 cycles (T0–T4);
  - indirect: 5 cycles.
- Each memory wait cycle adds one cycle, and `sc` holds during the wait.
- `mem_ack` arriving in the same cycle that `mem_rd` first rises is a valid zero-wait read.

## Test plan
- Reset then `start`, with `ir_q`=0x23 (I=0, op=2), zero-wait `mem_ack`, and `exec_done` at T4 → `t_state` 0x1,0x2,0x4,0x8,0x10; `d_bus`=0x04 from T3; `ld_ar_pc`@T0, `ld_ir`+`inc_pc`@T1, `ld_ar_ir`@T2; back at T0 on cycle 6.
- `ir_q`=0x95 (I=1, op=1), with `mem_ack` delayed 3 cycles at T3 → `mem_rd` high 4 cycles, `sc` held at 3, `ld_ar_mem` once, then T4 `exec_en`.
- `ir_q`=0x70 (D7) with `exec_done` at T3 → no ADDR memory read; next T0 after 4 cycles; `d_bus`=0x80.
- `halt_req` high during `exec_done` → `halted`=1, `t_state`=0; then `start` → FETCH0 next cycle.
- `exec_done` never asserted → `timeout`=1 when `sc`=15, followed by HALT; `start` clears `timeout`.
- `rst_n` pulsed low while `mem_rd` is waiting at T1 → all outputs 0 immediately; stray `mem_ack`/`exec_done` in IDLE has no effect.
